hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central pipeline controller for the 8-bit pipelined core.
- Drives stall/flush of the IF/ID and ID/EX pipeline registers: load-use hazards, taken branches, RET redirect bubbles, 2-byte instruction fetch, and the multi-cycle interrupt entry sequence.
- Sits beside decode and takes its status from the ID/EX register outputs. Its flush_E feeds that register's flush input directly.

Parameters:
- RET_BUBBLES, 3, number of cycles F/D/E are killed after a RET reaches EX (1..7).
- DRAIN_CYCLES, 2, cycles spent draining EX/MEM before interrupt push (1..3).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rd_en_E  input  1  instruction in EX is a memory load
- wr_en_regf_E  input  1  instruction in EX writes the register file
- RB_E  input  2  destination register of the instruction in EX
- ra_D, rb_D  input  2 each  source register fields in decode
- use_ra_D, use_rb_D  input  1 each  decode actually reads ra_D / rb_D
- is_2_byte_D  input  1  instruction in decode carries an immediate byte
- branch_taken_E  input  1  branch resolved taken in EX
- is_ret_E  input  1  RET/RTI in EX
- intr  input  1  external interrupt request, level, asynchronous to program flow
- stall_F  output  1  hold PC
- stall_D  output  1  hold IF/ID register
- flush_D  output  1  clear IF/ID register to NOP
- flush_E  output  1  clear ID/EX register to NOP
- int_push  output  1  push PC and flags this cycle
- pc_src_int  output  1  select interrupt vector as next PC
- intr_ack  output  1  one-cycle acknowledge
- state_o  output  3  current FSM state, for debug/verification

Behaviour:
- Reset: state=RUN, bubble counter=0, intr_pend=0. All outputs are 0 while reset is high, regardless of inputs.
- intr_pend: set on a clk edge where intr=1 and the previous sampled intr=0 (edge detect, 1-flop history). Cleared in the cycle intr_ack=1. If set and clear coincide, set wins.
- Encodings: RUN=0, IMM=1, RET_WAIT=2, INT_DRAIN=3, INT_PUSH=4, INT_JUMP=5. Codes 6 and 7 go to RUN next cycle with all outputs 0.
- RUN evaluates hazard conditions combinationally, in this priority order:
  1. is_ret_E: flush_D=flush_E=stall_F=1. Counter loads RET_BUBBLES-1. Next state RET_WAIT, or RUN if RET_BUBBLES=1.
  2. branch_taken_E: flush_D=flush_E=1 for this cycle only. Stay in RUN.
  3. Load-use, defined as rd_en_E & wr_en_regf_E & ((use_ra_D & ra_D==RB_E) | (use_rb_D & rb_D==RB_E)): stall_F=stall_D=flush_E=1 for one cycle. Stay in RUN.
  4. intr_pend: stall_F=flush_D=1. Counter loads DRAIN_CYCLES-1. Next state INT_DRAIN.
  5. is_2_byte_D: stall_D=flush_E=1. Next state IMM.
  6. Otherwise all outputs 0.
- IMM: exactly 1 cycle with stall_D=1 and flush_E=1 while the immediate byte is fetched, then RUN. If branch_taken_E or is_ret_E is asserted during IMM, apply the RUN rule for that event instead (redirect wins).
- RET_WAIT: flush_D=flush_E=stall_F=1. Counter decrements; go to RUN when counter==0. Total kill window = RET_BUBBLES cycles. intr is latched but not serviced until back in RUN.
- INT_DRAIN: stall_F=flush_D=1, flush_E=0 so in-flight instructions complete. Counter decrements; INT_PUSH when counter==0.
- INT_PUSH: 1 cycle, int_push=1, stall_F=1, flush_D=flush_E=1. Next state INT_JUMP.
- INT_JUMP: 1 cycle, pc_src_int=1, intr_ack=1, flush_D=1. Next state RUN.
- In INT_* states, branch_taken_E, is_ret_E and load-use inputs are ignored.
- Reset asserted mid-sequence: the next edge (asynchronous) returns to RUN, clears intr_pend, and drops all outputs the same instant.
- Latency:
  - Hazard response is 0 cycles (same-cycle combinational).
  - FSM transitions happen on the next clk.
  - Interrupt entry = 1 (detect) + DRAIN_CYCLES + 2 cycles from intr rising to intr_ack.

Test Plan:
- Reset: reset=1 with branch_taken_E=1, is_ret_E=1, intr=1 -> all outputs 0, state_o=0. Release reset -> intr_pend not set (history flop sampled during reset).
- Load-use: rd_en_E=1, wr_en_regf_E=1, RB_E=2, use_rb_D=1, rb_D=2 for 1 cycle -> stall_F=stall_D=flush_E=1 that cycle only. Same stimulus with wr_en_regf_E=0 -> outputs 0.
- RET with RET_BUBBLES=3: is_ret_E pulse -> flush_D/flush_E/stall_F high for exactly 3 consecutive cycles, state_o sequence 0,2,2,0.
- Interrupt with DRAIN_CYCLES=2: intr rising in RUN -> state_o 3,3,4,5,0. int_push in cycle 4, pc_src_int=intr_ack=1 in cycle 5, intr_pend cleared after.
- Collision: is_2_byte_D and branch_taken_E together -> flush_D=flush_E=1, stall_D=0, stays RUN. intr rising during RET_WAIT -> serviced immediately after RET_WAIT exits.
- Async reset during INT_PUSH -> int_push drops without a clk edge. Next state RUN, intr_pend=0.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Pipeline status and control bundle exchanged between decode/execute and the hazard sequencer.
interface hazard_sequencer_if;
    // Status from decode and the ID/EX register
    logic       rd_en_E;
    logic       wr_en_regf_E;
    logic [1:0] RB_E;
    logic [1:0] ra_D;
    logic [1:0] rb_D;
    logic       use_ra_D;
    logic       use_rb_D;
    logic       is_2_byte_D;
    logic       branch_taken_E;
    logic       is_ret_E;
    logic       intr;

    // Pipeline control back to fetch/decode/execute
    logic       stall_F;
    logic       stall_D;
    logic       flush_D;
    logic       flush_E;
    logic       int_push;
    logic       pc_src_int;
    logic       intr_ack;
    logic [2:0] state_o;

    // Sequencer side: consumes status, drives control
    modport master (
        input  rd_en_E, wr_en_regf_E, RB_E, ra_D, rb_D, use_ra_D, use_rb_D,
               is_2_byte_D, branch_taken_E, is_ret_E, intr,
        output stall_F, stall_D, flush_D, flush_E, int_push, pc_src_int,
               intr_ack, state_o
    );

    // Pipeline side: drives status, consumes control
    modport slave (
        output rd_en_E, wr_en_regf_E, RB_E, ra_D, rb_D, use_ra_D, use_rb_D,
               is_2_byte_D, branch_taken_E, is_ret_E, intr,
        input  stall_F, stall_D, flush_D, flush_E, int_push, pc_src_int,
               intr_ack, state_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Central pipeline controller: stall/flush of IF/ID and ID/EX for load-use,
// taken branches, RET kill window, 2-byte fetch and interrupt entry.
module hazard_sequencer #(
    parameter int unsigned RET_BUBBLES  = 3,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    hazard_sequencer_if.master hz
);

    localparam logic [2:0] RUN       = 3'd0;
    localparam logic [2:0] IMM       = 3'd1;
    localparam logic [2:0] RET_WAIT  = 3'd2;
    localparam logic [2:0] INT_DRAIN = 3'd3;
    localparam logic [2:0] INT_PUSH  = 3'd4;
    localparam logic [2:0] INT_JUMP  = 3'd5;

    localparam logic [2:0] RET_LOAD   = 3'(RET_BUBBLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       intr_q;
    logic       intr_pend;
    logic       load_use;

    logic       c_stall_F;
    logic       c_stall_D;
    logic       c_flush_D;
    logic       c_flush_E;
    logic       c_int_push;
    logic       c_pc_src_int;
    logic       c_intr_ack;

    assign load_use = hz.rd_en_E & hz.wr_en_regf_E &
                      ((hz.use_ra_D & (hz.ra_D == hz.RB_E)) |
                       (hz.use_rb_D & (hz.rb_D == hz.RB_E)));

    // Interrupt history flop: deliberately unreset so it keeps sampling while
    // reset is held, which stops a level already high at release from
    // looking like a fresh rising edge.
    always_ff @(posedge clk) begin
        intr_q <= hz.intr;
    end

    // Pending interrupt: set on rising edge of intr, cleared by acknowledge; set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intr_pend <= 1'b0;
        end else if (hz.intr & ~intr_q) begin
            intr_pend <= 1'b1;
        end else if (c_intr_ack) begin
            intr_pend <= 1'b0;
        end
    end

    // State and bubble/drain counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and raw control decode
    always_comb begin
        state_nx     = RUN;
        cnt_nx       = cnt;
        c_stall_F    = 1'b0;
        c_stall_D    = 1'b0;
        c_flush_D    = 1'b0;
        c_flush_E    = 1'b0;
        c_int_push   = 1'b0;
        c_pc_src_int = 1'b0;
        c_intr_ack   = 1'b0;

        case (state)
            // RUN and IMM share the redirect rules; IMM then falls back to
            // its fixed immediate-fetch bubble instead of the RUN hazard list.
            RUN, IMM: begin
                if (hz.is_ret_E) begin
                    c_flush_D = 1'b1;
                    c_flush_E = 1'b1;
                    c_stall_F = 1'b1;
                    cnt_nx    = RET_LOAD;
                    state_nx  = (RET_BUBBLES == 1) ? RUN : RET_WAIT;
                end else if (hz.branch_taken_E) begin
                    c_flush_D = 1'b1;
                    c_flush_E = 1'b1;
                end else if (state == IMM) begin
                    c_stall_D = 1'b1;
                    c_flush_E = 1'b1;
                end else if (load_use) begin
                    c_stall_F = 1'b1;
                    c_stall_D = 1'b1;
                    c_flush_E = 1'b1;
                end else if (intr_pend) begin
                    c_stall_F = 1'b1;
                    c_flush_D = 1'b1;
                    cnt_nx    = DRAIN_LOAD;
                    state_nx  = INT_DRAIN;
                end else if (hz.is_2_byte_D) begin
                    c_stall_D = 1'b1;
                    c_flush_E = 1'b1;
                    state_nx  = IMM;
                end
            end
            // The RUN cycle that sees the RET is the first bubble, so the
            // wait ends when the decremented count reaches zero.
            RET_WAIT: begin
                c_flush_D = 1'b1;
                c_flush_E = 1'b1;
                c_stall_F = 1'b1;
                cnt_nx    = cnt - 3'd1;
                state_nx  = (cnt <= 3'd1) ? RUN : RET_WAIT;
            end
            // The RUN detect cycle is not a drain cycle, so the drain spends
            // DRAIN_CYCLES cycles here and exits on a count already at zero.
            INT_DRAIN: begin
                c_stall_F = 1'b1;
                c_flush_D = 1'b1;
                if (cnt == 3'd0) begin
                    state_nx = INT_PUSH;
                end else begin
                    cnt_nx   = cnt - 3'd1;
                    state_nx = INT_DRAIN;
                end
            end
            INT_PUSH: begin
                c_int_push = 1'b1;
                c_stall_F  = 1'b1;
                c_flush_D  = 1'b1;
                c_flush_E  = 1'b1;
                state_nx   = INT_JUMP;
            end
            INT_JUMP: begin
                c_pc_src_int = 1'b1;
                c_intr_ack   = 1'b1;
                c_flush_D    = 1'b1;
                state_nx     = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        hz.stall_F    = c_stall_F    & ~reset;
        hz.stall_D    = c_stall_D    & ~reset;
        hz.flush_D    = c_flush_D    & ~reset;
        hz.flush_E    = c_flush_E    & ~reset;
        hz.int_push   = c_int_push   & ~reset;
        hz.pc_src_int = c_pc_src_int & ~reset;
        hz.intr_ack   = c_intr_ack   & ~reset;
        hz.state_o    = state;
    end

endmodule
